// File: rtl/router_pkg.sv
// router_pkg: widths, FIFO geometry and header field positions shared by the router blocks
package router_pkg;
    localparam int ROUTER_DATA_W     = 8;
    localparam int ROUTER_FIFO_DEPTH = 16;
    localparam int ROUTER_FIFO_AW    = 4;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-port output FIFO with header flags; ports clock/resetn/soft_reset, write_enb/read_enb/lfd_state/data_in in, data_out/empty/full out
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = ROUTER_DATA_W,
    parameter int DEPTH      = ROUTER_FIFO_DEPTH,
    parameter int ADDR_WIDTH = ROUTER_FIFO_AW
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [6:0]            pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH:0]   rd_entry;
    logic                  wr_acc, rd_acc;

    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                      (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign data_out = data_out_q;

    always_ff @(posedge clock)
        if (resetn && !soft_reset && wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};

    always_comb begin
        wr_ptr_d = soft_reset ? '0 : wr_ptr_q + (ADDR_WIDTH+1)'(wr_acc);
        rd_ptr_d = soft_reset ? '0 : rd_ptr_q + (ADDR_WIDTH+1)'(rd_acc);
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end

    // A header loads length+1 so the parity byte is counted; a zero count lets data_out idle to 0
    always_comb begin
        pkt_cnt_d  = soft_reset ? '0 :
                     !rd_acc ? pkt_cnt_q :
                     rd_entry[DATA_WIDTH] ? {1'b0, rd_entry[LEN_MSB:LEN_LSB]} + 7'd1 :
                     pkt_cnt_q != '0 ? pkt_cnt_q - 7'd1 : '0;
        data_out_d = soft_reset ? '0 :
                     rd_acc ? rd_entry[DATA_WIDTH-1:0] :
                     pkt_cnt_q == '0 ? '0 : data_out_q;
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: randomized and directed checks of router_fifo against a queue-based model
module tb_router_fifo;
    logic       clock = 0, resetn = 0, soft_reset = 0, write_enb = 0, read_enb = 0, lfd_state = 0;
    logic [7:0] data_in = 0, data_out;
    logic       empty, full;
    int         checks = 0, errors = 0;

    logic [8:0] q[$];
    int         m_cnt = 0;
    logic [7:0] m_dout = 0;

    router_fifo dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
        .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
        .data_out(data_out), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_cnt  = 0;
        m_dout = 0;
    endtask

    task automatic model_edge();
        bit racc, wacc;
        logic [8:0] e;
        if (!resetn) begin model_clear(); return; end
        if (soft_reset) begin model_clear(); return; end
        racc = read_enb && q.size() > 0;
        wacc = write_enb && q.size() < 16;
        if (racc) begin
            e = q.pop_front();
            m_dout = e[7:0];
            if (e[8]) m_cnt = int'(e[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
        end else if (m_cnt == 0) m_dout = 0;
        if (wacc) q.push_back({lfd_state, data_in});
    endtask

    task automatic cyc(input logic w, input logic r, input logic l, input logic [7:0] d, input logic sr);
        write_enb = w; read_enb = r; lfd_state = l; data_in = d; soft_reset = sr;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("data_out", data_out, m_dout);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == 16);
    endtask

    task automatic wr(input logic l, input logic [7:0] d); cyc(1, 0, l, d, 0); endtask
    task automatic rd(); cyc(0, 1, 0, 8'h00, 0); endtask
    task automatic idle(); cyc(0, 0, 0, 8'h00, 0); endtask

    initial begin
        logic [7:0] exp_pkt [5];
        exp_pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h3C};
        @(negedge clock);
        chk("reset_dout", data_out, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        idle();
        resetn = 1;
        idle();

        wr(1, 8'h0C); wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            rd();
            chk("pkt_byte", data_out, exp_pkt[i]);
        end
        idle();
        chk("pkt_idle_dout", data_out, 0);
        chk("pkt_idle_empty", empty, 1);

        wr(1, 8'h0C); wr(0, 8'h55); rd();
        chk("pre_async_dout", data_out, 8'h0C);
        #2 resetn = 0;
        #1;
        chk("async_dout", data_out, 0);
        chk("async_empty", empty, 1);
        chk("async_full", full, 0);
        model_clear();
        #1 resetn = 1;

        for (int i = 0; i < 16; i++) wr(0, 8'hA0 + 8'(i));
        chk("full_16", full, 1);
        wr(0, 8'hFF);
        chk("full_drop", full, 1);
        cyc(1, 1, 0, 8'hEE, 0);
        chk("full_rw_dout", data_out, 8'hA0);
        chk("full_rw_full", full, 0);
        for (int i = 1; i < 16; i++) rd();
        chk("drain_last", data_out, 8'hAF);
        chk("drain_empty", empty, 1);

        rd();
        chk("empty_rd_dout", data_out, 0);
        cyc(1, 1, 0, 8'h77, 0);
        chk("empty_rw_empty", empty, 0);
        chk("empty_rw_dout", data_out, 0);
        rd();
        chk("empty_rw_read", data_out, 8'h77);

        for (int i = 0; i < 3; i++) wr(0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 8'($urandom), 0);
            chk("wrap_no_flag", int'(empty | full), 0);
        end
        for (int i = 0; i < 3; i++) rd();
        idle();

        wr(1, 8'h08); wr(0, 8'h01); wr(0, 8'h02); wr(0, 8'h0B); wr(1, 8'h04); wr(0, 8'h09); wr(0, 8'h0D);
        rd(); rd();
        chk("pre_sr_dout", data_out, 8'h01);
        chk("pre_sr_cnt", m_cnt, 2);
        cyc(1, 1, 0, 8'h99, 1);
        chk("sr_empty", empty, 1);
        chk("sr_dout", data_out, 0);
        wr(1, 8'h10);
        rd();
        chk("sr_hdr_read", data_out, 8'h10);
        for (int i = 0; i < 4; i++) rd();
        idle();

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                1'($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom_range(0, 99) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
